ram_port_arbiter: RTL
=====================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter SIZE, default 4096, the number of byte locations in the arbitrated RAM.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(SIZE), the address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have ports req0_valid/req1_valid, input, 1 bit each: requester n presents a transaction.
REQ-006 SHALL have ports req0_addr/req1_addr, input, ADDR_WIDTH bits each: transaction address.
REQ-007 SHALL have ports req0_we/req1_we, input, 1 bit each: 1 = write, 0 = read.
REQ-008 SHALL have ports req0_wdata/req1_wdata, input, 8 bits each: write byte.
REQ-009 SHALL have ports req0_ready/req1_ready, output, 1 bit each: transaction accepted this cycle.
REQ-010 SHALL have ports resp0_valid/resp1_valid, output, 1 bit each: read data valid.
REQ-011 SHALL have ports resp0_rdata/resp1_rdata, output, 8 bits each: returned read byte.
REQ-012 SHALL have port clear_start, input, 1 bit: pulse that starts a fill sweep.
REQ-013 SHALL have port clear_value, input, 8 bits: fill byte, sampled when clear_start is accepted.
REQ-014 SHALL have port busy, output, 1 bit: sweep in progress.
REQ-015 SHALL have port clear_done, output, 1 bit: one-cycle pulse when the sweep completes.
REQ-016 SHALL have ports ram_addr (output, ADDR_WIDTH), ram_wdata (output, 8), ram_wenable (output, 1), ram_rdata (input, 8): connection to the RAM's read/write port, whose read is combinational and whose write lands on the clock edge.

Function
REQ-017 SHALL implement states IDLE and CLEAR.
REQ-018 In IDLE, with exactly one reqN_valid high, reqN_ready SHALL be asserted combinationally in the same cycle.
REQ-019 In IDLE, with both valid high, the requester other than last_grant SHALL be granted; last_grant SHALL update to the granted index on each accepted transaction.
REQ-020 At most one reqN_ready SHALL be high in any cycle; ready SHALL never be high without the matching valid.
REQ-021 The granted request SHALL drive ram_addr, ram_wdata and ram_wenable (= we) combinationally in its grant cycle.
REQ-022 With no grant in IDLE, ram_wenable SHALL be 0 and ram_addr/ram_wdata SHALL be 0.
REQ-023 An accepted read SHALL register ram_rdata into respN_rdata and pulse respN_valid for exactly one cycle, in the cycle after acceptance (latency 1).
REQ-024 An accepted write SHALL produce no response pulse.
REQ-025 respN_rdata SHALL hold its value until the next read response for that requester.
REQ-026 clear_start in IDLE SHALL latch clear_value, zero the sweep counter, and enter CLEAR on the next edge; a request granted in that same cycle SHALL still complete.
REQ-027 In CLEAR, busy SHALL be 1, both readys 0, ram_wenable 1, ram_addr = counter, ram_wdata = the latched fill byte; the counter SHALL increment each cycle.
REQ-028 CLEAR SHALL write exactly SIZE locations, 0..SIZE-1, taking SIZE cycles. After writing SIZE-1 it SHALL return to IDLE and pulse clear_done for one cycle in the first IDLE cycle.
REQ-029 clear_start while in CLEAR SHALL be ignored.
REQ-030 Requests held valid during CLEAR SHALL remain pending and be arbitrated normally from the first IDLE cycle.

Reset
REQ-031 Asserting rst SHALL immediately force: state IDLE, counter 0, last_grant 1 (requester 0 wins the first contention), resp*_valid 0, resp*_rdata 0, clear_done 0, busy 0, latched fill byte 0.
REQ-032 Reset during CLEAR SHALL abort the sweep with no clear_done pulse; locations already written stay written.

Structure
REQ-033 A shared package SHALL hold the state enumeration (IDLE, CLEAR) and requester index constants (REQ0 = 0, REQ1 = 1).
REQ-034 Arbitration SHALL be one sub-module, rr_arbiter2: valid pair and last_grant in, one-hot grant out, purely combinational. All registers SHALL live in ram_port_arbiter.

Verification
REQ-035 After reset, write 0xA5 to address 0x010 from req0, then read it from req1 -> req0_ready in cycle 0; resp1_valid one cycle after the read is accepted, with resp1_rdata = 0xA5.
REQ-036 Hold both valid for 4 cycles after reset -> grants REQ0, REQ1, REQ0, REQ1; never both ready.
REQ-037 clear_start with clear_value 0x3C, SIZE = 16 -> busy for 16 cycles; ram_addr goes 0..15; clear_done pulses once; a subsequent read of address 7 returns 0x3C.
REQ-038 req1 read held valid during CLEAR -> req1_ready stays 0 until the first IDLE cycle, then the request is accepted.
REQ-039 rst asserted at sweep cycle 5 -> outputs reach reset values without a clock edge; no clear_done pulse; address 6 is unmodified.
REQ-040 clear_start asserted in the same cycle as a req0 write of 0x11 to address 3 -> the write completes; the sweep starts on the next cycle and then overwrites address 3 with the fill byte.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_port_arbiter_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Requester indices, also the encoding of last_grant.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: on contention the requester that did not win last time is granted.
module rr_arbiter2
  import ram_port_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant_c
);

  // One-hot grant; a lone requester always wins, contention alternates.
  always_comb begin
    grant_c = 2'b00;
    if (valid[0] && valid[1]) begin
      grant_c = (last_grant == REQ0) ? 2'b10 : 2'b01;
    end else if (valid[0]) begin
      grant_c = 2'b01;
    end else if (valid[1]) begin
      grant_c = 2'b10;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one byte-wide RAM port between two requesters and a fill (clear) sweep engine.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned SIZE       = 4096,
  parameter int unsigned ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic                  req0_we,
  input  logic [7:0]            req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic                  req1_we,
  input  logic [7:0]            req1_wdata,
  output logic                  req1_ready,
  output logic                  resp0_valid,
  output logic [7:0]            resp0_rdata,
  output logic                  resp1_valid,
  output logic [7:0]            resp1_rdata,
  input  logic                  clear_start,
  input  logic [7:0]            clear_value,
  output logic                  busy,
  output logic                  clear_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_wdata,
  output logic                  ram_wenable,
  input  logic [7:0]            ram_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   counter;
  logic                    last_grant;
  logic [DATA_WIDTH-1:0]   fill_byte;
  logic [1:0]              arb_grant_c;
  logic [1:0]              grant;
  logic                    rd0_accept;
  logic                    rd1_accept;

  rr_arbiter2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant_c    (arb_grant_c)
  );

  // Grants only exist in IDLE; the sweep owns the RAM port during CLEAR.
  always_comb begin
    grant       = (state == IDLE) ? arb_grant_c : 2'b00;
    req0_ready  = grant[0];
    req1_ready  = grant[1];
    rd0_accept  = grant[0] & ~req0_we;
    rd1_accept  = grant[1] & ~req1_we;
    ram_addr    = '0;
    ram_wdata   = '0;
    ram_wenable = 1'b0;
    if (state == CLEAR) begin
      ram_addr    = counter;
      ram_wdata   = fill_byte;
      ram_wenable = 1'b1;
    end else if (grant[0]) begin
      ram_addr    = req0_addr;
      ram_wdata   = req0_wdata;
      ram_wenable = req0_we;
    end else if (grant[1]) begin
      ram_addr    = req1_addr;
      ram_wdata   = req1_wdata;
      ram_wenable = req1_we;
    end
  end

  // State, sweep counter, arbitration history and registered responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      counter     <= '0;
      last_grant  <= REQ1;
      fill_byte   <= '0;
      busy        <= 1'b0;
      clear_done  <= 1'b0;
      resp0_valid <= 1'b0;
      resp0_rdata <= '0;
      resp1_valid <= 1'b0;
      resp1_rdata <= '0;
    end else begin
      resp0_valid <= rd0_accept;
      resp1_valid <= rd1_accept;
      if (rd0_accept) resp0_rdata <= ram_rdata;
      if (rd1_accept) resp1_rdata <= ram_rdata;
      if (grant[0]) begin
        last_grant <= REQ0;
      end else if (grant[1]) begin
        last_grant <= REQ1;
      end
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_start) begin
            fill_byte <= clear_value;
            counter   <= '0;
            busy      <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          if (counter == LAST_ADDR) begin
            counter    <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b1;
            state      <= IDLE;
          end else begin
            counter <= counter + ADDR_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
